// File: rtl/cnn_conv_pkg.sv
// Shared constants for the streaming 3x3 convolution engine:
// register map, control/status bit positions and FSM states.
package cnn_conv_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_DIM    = 8'h08;
  localparam logic [7:0] REG_SHIFT  = 8'h0C;
  localparam logic [7:0] REG_W0     = 8'h10;
  localparam logic [7:0] REG_W8     = 8'h30;
  localparam logic [7:0] REG_BIAS   = 8'h34;
  localparam logic [7:0] REG_CNT    = 8'h38;

  localparam int CTRL_START = 0;
  localparam int CTRL_RELU  = 1;
  localparam int CTRL_IRQ   = 2;
  localparam int CTRL_ABORT = 3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_e;

endpackage

// File: rtl/cnn_line_buffer.sv
// Two-row line buffer and 3x3 window for raster pixels.
// win_o presents the window including the incoming column.
module cnn_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_IMG_W  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   pix_i,
  input  logic [15:0]             width_i,
  output logic [9*DATA_WIDTH-1:0] win_o,
  output logic                    win_valid_o,
  output logic [15:0]             row_o,
  output logic [15:0]             col_o
);

  localparam int AW = $clog2(MAX_IMG_W);

  logic [DATA_WIDTH-1:0] lb0 [MAX_IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [MAX_IMG_W];
  logic [DATA_WIDTH-1:0] win_q [3][2];
  logic [DATA_WIDTH-1:0] incol [3];
  logic [15:0]           row_q, col_q;
  logic [AW-1:0]         wa;

  assign wa    = col_q[AW-1:0];
  assign incol[0] = lb1[wa];
  assign incol[1] = lb0[wa];
  assign incol[2] = pix_i;

  // Line memories: lb0 holds the previous row, lb1 the one before.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      lb1[wa] <= lb0[wa];
      lb0[wa] <= pix_i;
    end
  end

  // Window shift and raster position counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en_i) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= incol[r];
      end
      if (col_q == width_i - 16'd1) begin
        col_q <= '0;
        row_q <= row_q + 16'd1;
      end else begin
        col_q <= col_q + 16'd1;
      end
    end
  end

  // Pack the window row-major, top-left first.
  always_comb begin
    win_o = '0;
    for (int r = 0; r < 3; r++) begin
      win_o[(r*3)*DATA_WIDTH +: DATA_WIDTH]   = win_q[r][0];
      win_o[(r*3+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][1];
      win_o[(r*3+2)*DATA_WIDTH +: DATA_WIDTH] = incol[r];
    end
  end

  assign win_valid_o = (row_q >= 16'd2) && (col_q >= 16'd2);
  assign row_o       = row_q;
  assign col_o       = col_q;

endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming 3x3 convolution: register file, job FSM,
// MAC stage and requantising output stage.
module cnn_conv_stream
  import cnn_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int MAX_IMG_W  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic                  reg_gnt_o,
  output logic                  reg_rvalid_o,
  output logic [31:0]           reg_rdata_o,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  busy_o,
  output logic                  irq_o
);

  localparam logic signed [ACC_WIDTH-1:0] UMAX =
    ACC_WIDTH'((1 << DATA_WIDTH) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMAX =
    ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;

  state_e state_q, state_d;
  logic [15:0] w_q, h_q, row, col;
  logic [4:0]  shift_q;
  logic [DATA_WIDTH-1:0] wgt_q [9];
  logic signed [ACC_WIDTH-1:0] bias_q, acc_d, acc_q, wx, px, a, s;
  logic [31:0] cnt_q, total, rdata_d;
  logic relu_q, irq_en_q, done_q, err_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [7:0]  addr;
  logic [3:0]  widx;
  logic wr, rd, is_w, start_w, abort_w, w1c, cfg_we;
  logic dims_ok, go, last_pix, last_res, done_set, err_set;
  logic adv, accept, res_hs, v1_q, ov_q, win_valid;
  logic [DATA_WIDTH-1:0] od_q, post_d;
  logic [9*DATA_WIDTH-1:0] win;

  assign addr    = 8'(reg_addr_i);
  assign wr      = reg_req_i & reg_we_i;
  assign rd      = reg_req_i & ~reg_we_i;
  assign is_w    = (addr >= REG_W0) && (addr <= REG_W8) &&
                   (addr[1:0] == 2'b00);
  assign widx    = 4'((addr - REG_W0) >> 2);
  assign start_w = wr && (addr == REG_CTRL) && reg_wdata_i[CTRL_START];
  assign abort_w = wr && (addr == REG_CTRL) && reg_wdata_i[CTRL_ABORT];
  assign w1c     = wr && (addr == REG_STATUS);
  assign cfg_we  = wr && (state_q == IDLE);

  assign dims_ok = (w_q >= 16'd3) && (w_q <= 16'(MAX_IMG_W)) &&
                   (h_q >= 16'd3);
  assign total   = 32'(w_q - 16'd2) * 32'(h_q - 16'd2);

  assign adv      = ~ov_q | res_ready_i;
  assign pix_ready_o = (state_q == STREAM) & adv;
  assign accept   = pix_valid_i & pix_ready_o;
  assign res_hs   = ov_q & res_ready_i;
  assign last_pix = accept && (col == w_q - 16'd1) &&
                    (row == h_q - 16'd1);
  assign last_res = res_hs && (cnt_q + 32'd1 == total);

  cnn_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_IMG_W  (MAX_IMG_W)
  ) u_lb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (go | abort_w),
    .en_i        (accept),
    .pix_i       (pix_data_i),
    .width_i     (w_q),
    .win_o       (win),
    .win_valid_o (win_valid),
    .row_o       (row),
    .col_o       (col)
  );

  // Job FSM next state and status set pulses.
  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_w && dims_ok) begin
          go      = 1'b1;
          state_d = STREAM;
        end else if (start_w) begin
          err_set  = 1'b1;
          done_set = 1'b1;
        end
      end
      STREAM: if (last_pix) state_d = DRAIN;
      DRAIN: begin
        if (last_res) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_w) begin
      state_d  = IDLE;
      go       = 1'b0;
      done_set = 1'b0;
      err_set  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Configuration, control and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_q      <= '0;
      h_q      <= '0;
      shift_q  <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      for (int k = 0; k < 9; k++) wgt_q[k] <= '0;
    end else begin
      if (wr && addr == REG_CTRL) begin
        irq_en_q <= reg_wdata_i[CTRL_IRQ];
        if (state_q == IDLE) relu_q <= reg_wdata_i[CTRL_RELU];
      end
      if (cfg_we && addr == REG_DIM) begin
        w_q <= reg_wdata_i[15:0];
        h_q <= reg_wdata_i[31:16];
      end
      if (cfg_we && addr == REG_SHIFT) shift_q <= reg_wdata_i[4:0];
      if (cfg_we && addr == REG_BIAS) bias_q <= reg_wdata_i[ACC_WIDTH-1:0];
      if (cfg_we && is_w) wgt_q[widx] <= reg_wdata_i[DATA_WIDTH-1:0];
      done_q <= done_set | (done_q & ~(w1c & reg_wdata_i[ST_DONE]));
      err_q  <= err_set | (err_q & ~(w1c & reg_wdata_i[ST_ERR]));
      if (go)          cnt_q <= '0;
      else if (res_hs) cnt_q <= cnt_q + 32'd1;
    end
  end

  // Read data mux.
  always_comb begin
    rdata_d = UNMAPPED;
    unique case (1'b1)
      addr == REG_CTRL:   rdata_d = {28'b0, 1'b0, irq_en_q, relu_q, 1'b0};
      addr == REG_STATUS: rdata_d = {29'b0, err_q, done_q, busy_o};
      addr == REG_DIM:    rdata_d = {h_q, w_q};
      addr == REG_SHIFT:  rdata_d = {27'b0, shift_q};
      is_w:               rdata_d = 32'(signed'(wgt_q[widx]));
      addr == REG_BIAS:   rdata_d = 32'(bias_q);
      addr == REG_CNT:    rdata_d = cnt_q;
      default:            rdata_d = UNMAPPED;
    endcase
  end

  // Register response, one cycle after each request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= reg_req_i;
      rdata_q  <= rd ? rdata_d : 32'd0;
    end
  end

  // Multiply-accumulate over the current window.
  always_comb begin
    acc_d = bias_q;
    wx    = '0;
    px    = '0;
    for (int k = 0; k < 9; k++) begin
      wx    = ACC_WIDTH'(signed'(wgt_q[k]));
      px    = ACC_WIDTH'(win[k*DATA_WIDTH +: DATA_WIDTH]);
      acc_d = acc_d + wx * px;
    end
  end

  // ReLU, shift and saturate.
  always_comb begin
    a = acc_q;
    if (relu_q && a < 0) a = '0;
    s = a >>> shift_q;
    post_d = s[DATA_WIDTH-1:0];
    if (relu_q) begin
      if (s > UMAX) post_d = '1;
    end else if (s > SMAX) begin
      post_d = SMAX[DATA_WIDTH-1:0];
    end else if (s < SMIN) begin
      post_d = SMIN[DATA_WIDTH-1:0];
    end
  end

  // Two-stage pipeline, advancing together under a global stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      ov_q  <= 1'b0;
      acc_q <= '0;
      od_q  <= '0;
    end else if (abort_w) begin
      v1_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (adv) begin
      v1_q  <= accept & win_valid;
      acc_q <= acc_d;
      ov_q  <= v1_q;
      od_q  <= post_d;
    end
  end

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign res_valid_o  = ov_q;
  assign res_data_o   = od_q;
  assign busy_o       = (state_q != IDLE);
  assign irq_o        = done_q & irq_en_q;

endmodule
